// File: rtl/ser_pkg.sv
// Shared widths for the serial-to-parallel converter.
package ser_pkg;
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned CNT_W      = $clog2(DEF_DATA_W);
  localparam int unsigned BYTE_CNT_W = 16;
endpackage

// File: rtl/sp_shift_reg.sv
// Serial shift register; word_c is the word as it stands after this cycle's clear/shift.
module sp_shift_reg #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en_i,
  input  logic              clear_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_c
);

  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [DATA_W-1:0] base;

  // Clear happens before the shift so a bit arriving with clear starts a new word.
  always_comb begin
    base    = clear_i ? '0 : shreg_q;
    shreg_d = base;
    if (shift_en_i) begin
      if (MSB_FIRST) shreg_d = {base[DATA_W-2:0], bit_i};
      else           shreg_d = {bit_i, base[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shreg_q <= '0;
    else        shreg_q <= shreg_d;
  end

  assign word_c = shreg_d;

endmodule

// File: rtl/ser_to_par_rev.sv
// Serial-to-parallel converter with valid/ready output, resync and word counter.
module ser_to_par_rev
  import ser_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sin_bit,
  input  logic                      sin_valid,
  output logic                      sin_ready,
  input  logic                      sync,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [$clog2(DATA_W)-1:0] bit_cnt,
  output logic [BYTE_CNT_W-1:0]     byte_cnt
);

  localparam int unsigned   BW   = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic                  accept;
  logic                  word_done;
  logic [DATA_W-1:0]     word_next;

  // Stall only the bit that would complete a word while the previous one is still held.
  assign sin_ready = !(dout_valid_q && !dout_ready && (bit_cnt_q == LAST));
  assign accept    = sin_valid && sin_ready;
  assign word_done = accept && !sync && (bit_cnt_q == LAST);

  sp_shift_reg #(
    .DATA_W    (DATA_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en_i (accept),
    .clear_i    (sync),
    .bit_i      (sin_bit),
    .word_c     (word_next)
  );

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    byte_cnt_d   = byte_cnt_q;

    if (sync)        bit_cnt_d = accept ? BW'(1) : '0;
    else if (accept) bit_cnt_d = word_done ? '0 : bit_cnt_q + BW'(1);

    if (word_done) begin
      dout_d       = word_next;
      dout_valid_d = 1'b1;
      byte_cnt_d   = byte_cnt_q + BYTE_CNT_W'(1);
    end else if (dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign bit_cnt    = bit_cnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
